// File: rtl/hbconsole_arbiter_if.sv
// Bundle of the hexbus, console, UART transmit and UART receive signals
// shared between the arbiter (slave) and its environment (master).
interface hbconsole_arbiter_if;
    logic       i_hb_stb;
    logic [6:0] i_hb_data;
    logic       i_hb_eol;
    logic       o_hb_busy;
    logic       i_con_stb;
    logic [6:0] i_con_data;
    logic       o_con_busy;
    logic       o_tx_stb;
    logic [7:0] o_tx_data;
    logic       i_tx_busy;
    logic       i_rx_stb;
    logic [7:0] i_rx_data;
    logic       o_hb_rx_stb;
    logic       o_con_rx_stb;
    logic [6:0] o_rx_data;
    logic [1:0] o_owner;

    modport slave (
        input  i_hb_stb, i_hb_data, i_hb_eol,
        output o_hb_busy,
        input  i_con_stb, i_con_data,
        output o_con_busy,
        output o_tx_stb, o_tx_data,
        input  i_tx_busy,
        input  i_rx_stb, i_rx_data,
        output o_hb_rx_stb, o_con_rx_stb, o_rx_data,
        output o_owner
    );

    modport master (
        output i_hb_stb, i_hb_data, i_hb_eol,
        input  o_hb_busy,
        output i_con_stb, i_con_data,
        input  o_con_busy,
        input  o_tx_stb, o_tx_data,
        output i_tx_busy,
        output i_rx_stb, i_rx_data,
        input  o_hb_rx_stb, o_con_rx_stb, o_rx_data,
        input  o_owner
    );
endinterface

// File: rtl/hbconsole_arbiter.sv
// Shares one UART byte stream between hexbus (bit 7 set) and console (bit 7 clear),
// switching owners only at packet/line boundaries, and splits the receive stream.
module hbconsole_arbiter #(
    parameter int LGTIMEOUT = 10,
    parameter int LGMAXLINE = 7
) (
    input  logic                i_clk,
    input  logic                i_reset,
    hbconsole_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HB   = 2'd1,
        S_CON  = 2'd2
    } owner_t;

    typedef enum logic {
        SRC_HB  = 1'b0,
        SRC_CON = 1'b1
    } src_t;

    localparam logic [LGTIMEOUT-1:0] IDLE_MAX = '1;
    localparam logic [LGMAXLINE:0]   LINE_MAX = {1'b1, {LGMAXLINE{1'b0}}};
    localparam logic [6:0]           NEWLINE  = 7'h0a;

    owner_t                 owner_q, owner_d;
    src_t                   last_q, last_d;
    logic [LGTIMEOUT-1:0]   idle_cnt_q, idle_cnt_d;
    logic [LGMAXLINE:0]     line_cnt_q, line_cnt_d;
    logic                   tx_stb_q, tx_stb_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   hb_rx_q, hb_rx_d;
    logic                   con_rx_q, con_rx_d;
    logic [6:0]             rx_data_q, rx_data_d;

    logic                   tx_ready;
    logic                   hb_wins_idle, con_wins_idle;
    logic                   grant_hb, grant_con;
    logic                   hb_acc, con_acc;
    logic                   con_nl;
    logic [LGTIMEOUT-1:0]   idle_inc;
    logic                   timeout;
    logic                   line_full, line_hit;

    // On a tie in IDLE the source that did not send last goes next.
    always_comb begin
        tx_ready      = !tx_stb_q || !bus.i_tx_busy;
        hb_wins_idle  = bus.i_hb_stb  && (!bus.i_con_stb || last_q == SRC_CON);
        con_wins_idle = bus.i_con_stb && (!bus.i_hb_stb  || last_q == SRC_HB);
        grant_hb      = (owner_q == S_HB)  || (owner_q == S_IDLE && hb_wins_idle);
        grant_con     = (owner_q == S_CON) || (owner_q == S_IDLE && con_wins_idle);
        hb_acc        = bus.i_hb_stb  && grant_hb  && tx_ready;
        con_acc       = bus.i_con_stb && grant_con && tx_ready;
        con_nl        = (bus.i_con_data == NEWLINE);
        idle_inc      = idle_cnt_q + LGTIMEOUT'(1);
        timeout       = (idle_inc == IDLE_MAX);
        line_full     = (line_cnt_q == LINE_MAX);
        line_hit      = bus.i_hb_stb && line_full;
    end

    assign bus.o_hb_busy  = !(grant_hb  && tx_ready);
    assign bus.o_con_busy = !(grant_con && tx_ready);

    // Counters only run while the console owns the link and are zero on entry.
    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        idle_cnt_d = '0;
        line_cnt_d = '0;
        case (owner_q)
            S_IDLE: begin
                if (hb_acc && !bus.i_hb_eol)
                    owner_d = S_HB;
                else if (con_acc && !con_nl)
                    owner_d = S_CON;
            end
            S_HB: begin
                if (hb_acc && bus.i_hb_eol)
                    owner_d = S_IDLE;
            end
            S_CON: begin
                idle_cnt_d = con_acc ? '0 : idle_inc;
                line_cnt_d = (con_acc && !line_full) ? line_cnt_q + (LGMAXLINE+1)'(1)
                                                      : line_cnt_q;
                // An accept in the timeout cycle keeps the grant alive.
                if ((con_acc && con_nl) || (!con_acc && timeout) || line_hit)
                    owner_d = S_IDLE;
            end
            default: owner_d = S_IDLE;
        endcase
        if (hb_acc)
            last_d = SRC_HB;
        else if (con_acc)
            last_d = SRC_CON;
    end

    always_comb begin
        tx_stb_d  = tx_stb_q;
        tx_data_d = tx_data_q;
        if (hb_acc) begin
            tx_stb_d  = 1'b1;
            tx_data_d = {1'b1, bus.i_hb_data};
        end else if (con_acc) begin
            tx_stb_d  = 1'b1;
            tx_data_d = {1'b0, bus.i_con_data};
        end else if (!bus.i_tx_busy) begin
            tx_stb_d  = 1'b0;
        end
    end

    always_comb begin
        hb_rx_d   = bus.i_rx_stb &&  bus.i_rx_data[7];
        con_rx_d  = bus.i_rx_stb && !bus.i_rx_data[7];
        rx_data_d = bus.i_rx_stb ? bus.i_rx_data[6:0] : rx_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            owner_q    <= S_IDLE;
            last_q     <= SRC_CON;
            idle_cnt_q <= '0;
            line_cnt_q <= '0;
            tx_stb_q   <= 1'b0;
            tx_data_q  <= '0;
            hb_rx_q    <= 1'b0;
            con_rx_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            idle_cnt_q <= idle_cnt_d;
            line_cnt_q <= line_cnt_d;
            tx_stb_q   <= tx_stb_d;
            tx_data_q  <= tx_data_d;
            hb_rx_q    <= hb_rx_d;
            con_rx_q   <= con_rx_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign bus.o_tx_stb     = tx_stb_q;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_hb_rx_stb  = hb_rx_q;
    assign bus.o_con_rx_stb = con_rx_q;
    assign bus.o_rx_data    = rx_data_q;
    assign bus.o_owner      = owner_q;

endmodule

// File: tb/tb_hbconsole_arbiter.sv
// Directed vector bench for hbconsole_arbiter: one row per clock cycle plus
// hand sequences for timeout, backpressure and line-limit behaviour.
module tb_hbconsole_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hbconsole_arbiter_if bus ();

    hbconsole_arbiter #(
        .LGTIMEOUT (4),
        .LGMAXLINE (3)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic       rst;
        logic       hs;  logic [6:0] hd; logic he;
        logic       cs;  logic [6:0] cd;
        logic       tb;
        logic       rs;  logic [7:0] rd;
        logic       ehb; logic       ecb;
        logic       etxs; logic [7:0] etxd;
        logic [1:0] eown;
        logic       ehr; logic       ecr; logic [6:0] erxd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic r, input logic hs, input logic [6:0] hd, input logic he,
        input logic cs, input logic [6:0] cd, input logic tb,
        input logic rs, input logic [7:0] rd,
        input logic ehb, input logic ecb, input logic etxs, input logic [7:0] etxd,
        input logic [1:0] eown, input logic ehr, input logic ecr, input logic [6:0] erxd);
        vec_t v;
        v.rst = r;  v.hs = hs; v.hd = hd; v.he = he; v.cs = cs; v.cd = cd; v.tb = tb;
        v.rs = rs;  v.rd = rd; v.ehb = ehb; v.ecb = ecb; v.etxs = etxs; v.etxd = etxd;
        v.eown = eown; v.ehr = ehr; v.ecr = ecr; v.erxd = erxd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic hs, input logic [6:0] hd, input logic he,
                         input logic cs, input logic [6:0] cd, input logic tb,
                         input logic rs, input logic [7:0] rd);
        rst = r;
        bus.i_hb_stb = hs;  bus.i_hb_data = hd;  bus.i_hb_eol = he;
        bus.i_con_stb = cs; bus.i_con_data = cd;
        bus.i_tx_busy = tb;
        bus.i_rx_stb = rs;  bus.i_rx_data = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int n;

        drive(1'b1, 0, 7'h00, 0, 0, 7'h00, 0, 0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_stb",  32'(bus.o_tx_stb),     32'h0);
        chk("reset_tx_data", 32'(bus.o_tx_data),    32'h0);
        chk("reset_owner",   32'(bus.o_owner),      32'h0);
        chk("reset_hb_rx",   32'(bus.o_hb_rx_stb),  32'h0);
        chk("reset_con_rx",  32'(bus.o_con_rx_stb), 32'h0);
        chk("reset_rx_data", 32'(bus.o_rx_data),    32'h0);
        rst = 1'b0;

        //     rst hs hd     he cs cd     tb rs rd      ehb ecb txs txd    own hr cr rxd
        // hexbus-only packet 12 34 56(eol)
        vt.push_back(mk(0, 1, 7'h12, 0, 0, 7'h00, 0, 0, 8'h00,  0, 1, 1, 8'h92, 2'd1, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h34, 0, 0, 7'h00, 0, 0, 8'h00,  0, 1, 1, 8'hB4, 2'd1, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h56, 1, 0, 7'h00, 0, 0, 8'h00,  0, 1, 1, 8'hD6, 2'd0, 0, 0, 7'h00));
        vt.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 0, 0, 8'h00,  1, 1, 0, 8'hD6, 2'd0, 0, 0, 7'h00));
        // console "ab", hexbus waits mid-line, newline releases
        vt.push_back(mk(0, 0, 7'h00, 0, 1, 7'h61, 0, 0, 8'h00,  1, 0, 1, 8'h61, 2'd2, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h21, 1, 1, 7'h62, 0, 0, 8'h00,  1, 0, 1, 8'h62, 2'd2, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h21, 1, 1, 7'h0a, 0, 0, 8'h00,  1, 0, 1, 8'h0A, 2'd0, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h21, 1, 0, 7'h00, 0, 0, 8'h00,  0, 1, 1, 8'hA1, 2'd0, 0, 0, 7'h00));
        vt.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 0, 0, 8'h00,  1, 1, 0, 8'hA1, 2'd0, 0, 0, 7'h00));
        // reset, then tie: hexbus first, console after hexbus eol
        vt.push_back(mk(1, 0, 7'h00, 0, 0, 7'h00, 0, 0, 8'h00,  1, 1, 0, 8'h00, 2'd0, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h05, 0, 1, 7'h43, 0, 0, 8'h00,  0, 1, 1, 8'h85, 2'd1, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h06, 1, 1, 7'h43, 0, 0, 8'h00,  0, 1, 1, 8'h86, 2'd0, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h07, 1, 1, 7'h43, 0, 0, 8'h00,  1, 0, 1, 8'h43, 2'd2, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h07, 1, 1, 7'h0a, 0, 0, 8'h00,  1, 0, 1, 8'h0A, 2'd0, 0, 0, 7'h00));
        vt.push_back(mk(0, 1, 7'h07, 1, 0, 7'h00, 0, 0, 8'h00,  0, 1, 1, 8'h87, 2'd0, 0, 0, 7'h00));
        vt.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 0, 0, 8'h00,  1, 1, 0, 8'h87, 2'd0, 0, 0, 7'h00));
        // receive split
        vt.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 0, 1, 8'hC5,  1, 1, 0, 8'h87, 2'd0, 1, 0, 7'h45));
        vt.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 0, 1, 8'h45,  1, 1, 0, 8'h87, 2'd0, 0, 1, 7'h45));
        vt.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 0, 0, 8'hFF,  1, 1, 0, 8'h87, 2'd0, 0, 0, 7'h45));
        // reset in the middle of a hexbus packet and receive stream
        vt.push_back(mk(0, 1, 7'h11, 0, 0, 7'h00, 0, 1, 8'h80,  0, 1, 1, 8'h91, 2'd1, 1, 0, 7'h00));
        vt.push_back(mk(1, 0, 7'h00, 0, 0, 7'h00, 0, 1, 8'h3C,  0, 1, 0, 8'h00, 2'd0, 0, 0, 7'h00));
        vt.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 0, 0, 8'h00,  1, 1, 0, 8'h00, 2'd0, 0, 0, 7'h00));

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].hs, vt[i].hd, vt[i].he, vt[i].cs, vt[i].cd,
                  vt[i].tb, vt[i].rs, vt[i].rd);
            #1;
            chk($sformatf("v%0d_hb_busy", i),  32'(bus.o_hb_busy),  32'(vt[i].ehb));
            chk($sformatf("v%0d_con_busy", i), 32'(bus.o_con_busy), 32'(vt[i].ecb));
            tick();
            chk($sformatf("v%0d_tx_stb", i),  32'(bus.o_tx_stb),     32'(vt[i].etxs));
            chk($sformatf("v%0d_tx_data", i), 32'(bus.o_tx_data),    32'(vt[i].etxd));
            chk($sformatf("v%0d_owner", i),   32'(bus.o_owner),      32'(vt[i].eown));
            chk($sformatf("v%0d_hb_rx", i),   32'(bus.o_hb_rx_stb),  32'(vt[i].ehr));
            chk($sformatf("v%0d_con_rx", i),  32'(bus.o_con_rx_stb), 32'(vt[i].ecr));
            chk($sformatf("v%0d_rx_data", i), 32'(bus.o_rx_data),    32'(vt[i].erxd));
        end

        // console timeout: 'A' then silence while hexbus waits
        drive(0, 0, 7'h00, 0, 1, 7'h41, 0, 0, 8'h00);
        #1;
        chk("to_con_busy", 32'(bus.o_con_busy), 32'h0);
        tick();
        chk("to_tx_data", 32'(bus.o_tx_data), 32'h41);
        drive(0, 1, 7'h33, 1, 0, 7'h00, 0, 0, 8'h00);
        #1;
        n = 0;
        while (bus.o_owner == 2'd2 && n < 40) begin
            chk("to_hb_waits", 32'(bus.o_hb_busy), 32'h1);
            n++;
            tick();
        end
        chk("to_con_cycles", 32'(n), 32'd15);
        chk("to_owner_idle", 32'(bus.o_owner), 32'h0);
        chk("to_hb_granted", 32'(bus.o_hb_busy), 32'h0);
        tick();
        chk("to_hb_data", 32'(bus.o_tx_data), 32'hB3);
        chk("to_hb_stb",  32'(bus.o_tx_stb),  32'h1);

        // backpressure: output held while transmitter is busy
        drive(0, 1, 7'h44, 0, 0, 7'h00, 0, 0, 8'h00);
        #1;
        chk("bp_first_acc", 32'(bus.o_hb_busy), 32'h0);
        tick();
        chk("bp_first_data", 32'(bus.o_tx_data), 32'hC4);
        drive(0, 1, 7'h45, 1, 1, 7'h50, 1, 0, 8'h00);
        #1;
        for (int k = 0; k < 20; k++) begin
            chk("bp_hb_busy",  32'(bus.o_hb_busy),  32'h1);
            chk("bp_con_busy", 32'(bus.o_con_busy), 32'h1);
            tick();
            chk("bp_hold_stb",  32'(bus.o_tx_stb),  32'h1);
            chk("bp_hold_data", 32'(bus.o_tx_data), 32'hC4);
        end
        bus.i_tx_busy = 1'b0;
        #1;
        chk("bp_release_hb",  32'(bus.o_hb_busy),  32'h0);
        chk("bp_release_con", 32'(bus.o_con_busy), 32'h1);
        tick();
        chk("bp_next_data",  32'(bus.o_tx_data), 32'hC5);
        chk("bp_next_owner", 32'(bus.o_owner),   32'h0);
        bus.i_hb_stb = 1'b0;
        #1;
        chk("bp_con_turn", 32'(bus.o_con_busy), 32'h0);
        tick();
        chk("bp_con_data",  32'(bus.o_tx_data), 32'h50);
        chk("bp_con_owner", 32'(bus.o_owner),   32'h2);
        bus.i_con_data = 7'h0a;
        tick();
        chk("bp_nl_data",  32'(bus.o_tx_data), 32'h0A);
        chk("bp_nl_owner", 32'(bus.o_owner),   32'h0);

        // line limit: endless console line must yield to a waiting hexbus
        drive(0, 0, 7'h00, 0, 1, 7'h31, 0, 0, 8'h00);
        tick();
        chk("ll_con_owner", 32'(bus.o_owner), 32'h2);
        bus.i_hb_stb = 1'b1; bus.i_hb_data = 7'h77; bus.i_hb_eol = 1'b1;
        #1;
        n = 0;
        while (bus.o_owner == 2'd2 && n < 20) begin
            n++;
            tick();
        end
        chk("ll_released", 32'(n < 20), 32'h1);
        tick();
        chk("ll_hb_data", 32'(bus.o_tx_data), 32'hF7);
        drive(0, 0, 7'h00, 0, 0, 7'h00, 0, 0, 8'h00);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
